// File: rtl/stuff_encoder.sv
// Bit-stuffing serializer: inserts a complementary stuff bit after STUFF_LEN
// identical transmitted bits. All bit-level state advances only on the TP
// strobe; TX idles recessive (1) whenever no frame is in flight.
module stuff_encoder #(
    // Run length that triggers a stuff bit; cnt is 3 bits, so 1..7 is legal.
    parameter int STUFF_LEN = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic TP,
    input  logic data_in,
    input  logic data_valid,
    input  logic data_last,
    input  logic F_STF,
    output logic data_ready,
    output logic TX,
    output logic stuff_flag,
    output logic underrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } state_t;

    localparam logic [2:0] LEN = 3'(STUFF_LEN);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       last;
    logic       last_nxt;
    logic       tx_nxt;
    logic       sf_nxt;
    logic       uf_nxt;
    // Remembers that the bit preceding a scheduled stuff bit closed the frame.
    logic       end_pend;
    logic       end_pend_nxt;
    // Run length as it would be after consuming data_in this TP.
    logic [2:0] run_cnt;
    logic       hit;

    // A bit is consumed only on a TP, outside the stuff slot, and never in reset.
    assign data_ready = TP & data_valid & (state != STUFF) & reset;

    // Run-length update for the offered bit; saturates so cnt never wraps.
    always_comb begin
        run_cnt = 3'd1;
        if (state == SEND) begin
            if (F_STF) begin
                run_cnt = 3'd0;
            end else if (data_in == last) begin
                run_cnt = (cnt >= LEN) ? LEN : cnt + 3'd1;
            end
        end
    end

    // A completed run schedules the stuff bit, even on the frame's last bit.
    assign hit = (run_cnt == LEN);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; only a TP can move the machine.
    always_comb begin
        state_nxt = state;
        if (TP) begin
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        state_nxt = hit ? STUFF : (data_last ? IDLE : SEND);
                    end
                end
                SEND: begin
                    if (data_valid) begin
                        state_nxt = hit ? STUFF : (data_last ? IDLE : SEND);
                    end else begin
                        // Source starved mid-frame: abandon the frame.
                        state_nxt = IDLE;
                    end
                end
                STUFF: begin
                    state_nxt = end_pend ? IDLE : SEND;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output / datapath next values; everything holds between TPs.
    always_comb begin
        tx_nxt       = TX;
        cnt_nxt      = cnt;
        last_nxt     = last;
        sf_nxt       = stuff_flag;
        end_pend_nxt = end_pend;
        uf_nxt       = 1'b0;
        if (TP) begin
            sf_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        tx_nxt       = data_in;
                        last_nxt     = data_in;
                        cnt_nxt      = run_cnt;
                        end_pend_nxt = data_last;
                    end else begin
                        tx_nxt  = 1'b1;
                        cnt_nxt = 3'd0;
                    end
                end
                SEND: begin
                    if (data_valid) begin
                        tx_nxt       = data_in;
                        last_nxt     = data_in;
                        cnt_nxt      = run_cnt;
                        end_pend_nxt = data_last;
                    end else begin
                        tx_nxt  = 1'b1;
                        cnt_nxt = 3'd0;
                        uf_nxt  = 1'b1;
                    end
                end
                STUFF: begin
                    // Stuff bit opens the next run; F_STF is not consulted here.
                    tx_nxt   = ~last;
                    last_nxt = ~last;
                    cnt_nxt  = 3'd1;
                    sf_nxt   = 1'b1;
                end
                default: begin
                    tx_nxt  = 1'b1;
                    cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // Datapath registers; reset drops any pending stuff bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            TX         <= 1'b1;
            cnt        <= 3'd0;
            last       <= 1'b1;
            stuff_flag <= 1'b0;
            underrun   <= 1'b0;
            end_pend   <= 1'b0;
        end else begin
            TX         <= tx_nxt;
            cnt        <= cnt_nxt;
            last       <= last_nxt;
            stuff_flag <= sf_nxt;
            underrun   <= uf_nxt;
            end_pend   <= end_pend_nxt;
        end
    end

endmodule
